// File: rtl/pc_seq_pkg.sv
// Shared encodings and default vectors for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch port between the PC sequencer (master) and the instruction memory (slave).
interface pc_sequencer_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            pc_valid_o;
    logic            if_ready_i;

    modport master (
        output pc_o,
        output pc_plus4_o,
        output pc_valid_o,
        input  if_ready_i
    );

    modport slave (
        input  pc_o,
        input  pc_plus4_o,
        input  pc_valid_o,
        output if_ready_i
    );

endinterface

// File: rtl/pc_hist_pipe.sv
// Fetch-PC history: hist[0] is the newest accepted fetch PC, hist[HIST_DEPTH-1] the oldest.
module pc_hist_pipe #(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [XLEN-1:0]                     din,
    output logic [HIST_DEPTH-1:0][XLEN-1:0]     hist
);

    // NOTE: the history is a handful of flops rather than a RAM, so it is reset
    // along with the rest of the sequencer; a stale entry would otherwise leak
    // into the first EPC or branch target after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (en) begin
            hist[0] <= din;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection for the fetch stage: fixed-priority redirect mux, FSM, EPC capture.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              HIST_DEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    pc_sequencer_if.master         fetch,
    input  logic                   branch_i,
    input  logic                   zero_i,
    input  logic [XLEN-1:0]        br_offset_i,
    input  logic                   jump_i,
    input  logic [25:0]            jump_index_i,
    input  logic                   jr_i,
    input  logic [XLEN-1:0]        jr_target_i,
    input  logic                   exc_i,
    input  logic                   halt_i,
    input  logic                   resume_i,
    output logic [XLEN-1:0]        epc_o,
    output logic                   misalign_o,
    output logic [1:0]             state_o
);

    state_e                         state, state_nxt;
    logic [XLEN-1:0]                pc, pc_nxt, pc_plus4;
    logic [XLEN-1:0]                base, br_target, jmp_target, jr_target;
    logic [HIST_DEPTH-1:0][XLEN-1:0] hist;
    logic                           pc_valid, fire, active, mis_nxt;

    assign active = (state == ST_RUN) && !stall_i;
    assign fire   = pc_valid && fetch.if_ready_i && !stall_i;

    pc_hist_pipe #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .en   (fire),
        .din  (pc),
        .hist (hist)
    );

    // Late-resolved targets are relative to the resolving instruction, not to pc.
    assign base       = hist[HIST_DEPTH-1];
    assign pc_plus4   = pc + XLEN'(PC_STEP);
    assign br_target  = base + XLEN'(PC_STEP) + (br_offset_i << 2);
    assign jmp_target = {base[XLEN-1:28], jump_index_i, 2'b00};
    assign jr_target  = {jr_target_i[XLEN-1:2], 2'b00};

    // NOTE: every combinational output gets a default before the priority chain,
    // so no path through the ifs leaves a signal unassigned and infers a latch.
    always_comb begin
        pc_nxt  = pc;
        mis_nxt = 1'b0;
        if (exc_i) begin
            pc_nxt = EXC_VECTOR;
        end else if (active) begin
            if (jr_i) begin
                pc_nxt  = jr_target;
                mis_nxt = |jr_target_i[1:0];
            end else if (jump_i) begin
                pc_nxt = jmp_target;
            end else if (branch_i && zero_i) begin
                pc_nxt = br_target;
            end else if (fire) begin
                pc_nxt = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (exc_i) begin
            state_nxt = ST_RUN;
        end else if (!stall_i) begin
            unique case (state)
                ST_BOOT: state_nxt = ST_RUN;
                ST_RUN:  if (halt_i)   state_nxt = ST_HALT;
                ST_HALT: if (resume_i) state_nxt = ST_RUN;
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        pc_valid = (state == ST_RUN);
        state_o  = state;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_VECTOR;
            epc_o      <= '0;
            misalign_o <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            misalign_o <= mis_nxt;
            if (exc_i) begin
                epc_o <= (state == ST_BOOT) ? RESET_VECTOR : base;
            end
        end
    end

    assign fetch.pc_o       = pc;
    assign fetch.pc_plus4_o = pc_plus4;
    assign fetch.pc_valid_o = pc_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch state queued per step, compared after the edge.
module tb_pc_sequencer;

    localparam logic [8:0] RDY = 9'h100, STL = 9'h080, BR  = 9'h040, ZR  = 9'h020,
                           JMP = 9'h010, JR  = 9'h008, EXC = 9'h004, HLT = 9'h002,
                           RES = 9'h001;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        vld;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] epc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, zero, jump, jr, exc, halt, resume;
    logic [31:0] br_offset, jr_target, epc;
    logic [25:0] jump_index;
    logic        misalign;
    logic [1:0]  state;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) fetch ();

    pc_sequencer #(.XLEN(32), .HIST_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .fetch        (fetch),
        .branch_i     (branch),
        .zero_i       (zero),
        .br_offset_i  (br_offset),
        .jump_i       (jump),
        .jump_index_i (jump_index),
        .jr_i         (jr),
        .jr_target_i  (jr_target),
        .exc_i        (exc),
        .halt_i       (halt),
        .resume_i     (resume),
        .epc_o        (epc),
        .misalign_o   (misalign),
        .state_o      (state)
    );

    // Drive one cycle of inputs, queue what must appear after the edge, sample it #1 later.
    task automatic step(input string tag, input logic [8:0] ctl, input logic [31:0] off,
                        input logic [31:0] jrt, input logic [25:0] idx, input logic [31:0] pc,
                        input logic vld, input logic [1:0] st, input logic mis,
                        input logic [31:0] e_epc);
        obs_t e, o;
        {fetch.if_ready_i, stall, branch, zero, jump, jr, exc, halt, resume} = ctl;
        br_offset  = off;
        jr_target  = jrt;
        jump_index = idx;
        e.tag = tag; e.pc = pc; e.p4 = pc + 32'd4; e.vld = vld; e.st = st;
        e.mis = mis; e.epc = e_epc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.tag = tag; o.pc = fetch.pc_o; o.p4 = fetch.pc_plus4_o; o.vld = fetch.pc_valid_o;
        o.st = state; o.mis = misalign; o.epc = epc;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {fetch.if_ready_i, stall, branch, zero, jump, jr, exc, halt, resume} = RDY;
        br_offset = '0; jr_target = '0; jump_index = '0;
        #12;
        vectors++;
        if ({fetch.pc_o, fetch.pc_plus4_o, fetch.pc_valid_o, state, misalign, epc} !==
            {32'h0, 32'h4, 1'b0, 2'd0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=0 p4=4 vld=0 st=0 mis=0 epc=0",
                     fetch.pc_o, fetch.pc_plus4_o, fetch.pc_valid_o, state, misalign, epc);
        end
        @(negedge clk);
        rst = 1'b0;
        step("boot_exit", RDY, 0, 0, 0, 32'h0, 1, 2'd1, 0, 32'h0);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    task automatic test_sequential();
        step("seq_4", RDY, 0, 0, 0, 32'h4, 1, 2'd1, 0, 32'h0);
        step("seq_8", RDY, 0, 0, 0, 32'h8, 1, 2'd1, 0, 32'h0);
        for (int i = 0; i < 3; i++) step("not_ready_hold", 9'h000, 0, 0, 0, 32'h8, 1, 2'd1, 0, 32'h0);
        step("seq_c", RDY, 0, 0, 0, 32'hC, 1, 2'd1, 0, 32'h0);
        step("seq_10", RDY, 0, 0, 0, 32'h10, 1, 2'd1, 0, 32'h0);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    // hist[1]=0x08 at pc=0x10, so a taken offset of -2 lands on 0x08+4-8 = 0x04.
    task automatic test_branch();
        step("br_not_taken_no_fire", BR, 32'hFFFF_FFFE, 0, 0, 32'h10, 1, 2'd1, 0, 32'h0);
        step("br_taken", RDY | BR | ZR, 32'hFFFF_FFFE, 0, 0, 32'h4, 1, 2'd1, 0, 32'h0);
        step("br_not_taken", RDY | BR, 32'hFFFF_FFFE, 0, 0, 32'h8, 1, 2'd1, 0, 32'h0);
        step("br_taken_no_fire", BR | ZR, 32'h1, 0, 0, 32'h18, 1, 2'd1, 0, 32'h0);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    task automatic test_jump_jr();
        step("jr_over_jump", RDY | JMP | JR, 0, 32'h203, 26'h40, 32'h200, 1, 2'd1, 1, 32'h0);
        step("misalign_clears", RDY, 0, 0, 0, 32'h204, 1, 2'd1, 0, 32'h0);
        step("jump", RDY | JMP, 0, 0, 26'h40, 32'h100, 1, 2'd1, 0, 32'h0);
        step("jr_aligned", RDY | JR, 0, 32'h40, 0, 32'h40, 1, 2'd1, 0, 32'h0);
        step("seq_44", RDY, 0, 0, 0, 32'h44, 1, 2'd1, 0, 32'h0);
        step("seq_48", RDY, 0, 0, 0, 32'h48, 1, 2'd1, 0, 32'h0);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    // At pc=0x48 the history holds hist[1]=0x40.
    task automatic test_exception();
        step("stall_ignores_jr", RDY | STL | JMP | JR, 0, 32'h203, 26'h40, 32'h48, 1, 2'd1, 0, 32'h0);
        step("stall_ignores_halt", RDY | STL | HLT, 0, 0, 0, 32'h48, 1, 2'd1, 0, 32'h0);
        step("exc_under_stall", RDY | STL | EXC, 0, 0, 0, 32'h180, 1, 2'd1, 0, 32'h40);
        step("exc_over_jr", RDY | EXC | JR | JMP, 0, 32'h203, 26'h40, 32'h180, 1, 2'd1, 0, 32'h40);
        step("post_exc", RDY, 0, 0, 0, 32'h184, 1, 2'd1, 0, 32'h40);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    task automatic test_halt();
        step("halt", RDY | HLT, 0, 0, 0, 32'h188, 0, 2'd2, 0, 32'h40);
        for (int i = 0; i < 2; i++) step("halt_hold", RDY, 0, 0, 0, 32'h188, 0, 2'd2, 0, 32'h40);
        step("resume", RDY | RES, 0, 0, 0, 32'h188, 1, 2'd1, 0, 32'h40);
        step("run_18c", RDY, 0, 0, 0, 32'h18C, 1, 2'd1, 0, 32'h40);
        step("halt_with_jump", RDY | HLT | JMP, 0, 0, 26'h80, 32'h200, 0, 2'd2, 0, 32'h40);
        step("exc_leaves_halt", EXC, 0, 0, 0, 32'h180, 1, 2'd1, 0, 32'h188);
        step("halt_again", RDY | HLT, 0, 0, 0, 32'h184, 0, 2'd2, 0, 32'h188);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    // Asynchronous reset while halted, exception straight out of BOOT, then the 2^32 wrap.
    task automatic test_reset_recovery();
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({fetch.pc_o, fetch.pc_valid_o, state, misalign, epc} !== {32'h0, 1'b0, 2'd0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_mid_halt: got pc=%h vld=%b st=%0d mis=%b epc=%h, want pc=0 vld=0 st=0 mis=0 epc=0",
                     fetch.pc_o, fetch.pc_valid_o, state, misalign, epc);
        end
        @(negedge clk);
        rst = 1'b0;
        step("exc_in_boot", EXC, 0, 0, 0, 32'h180, 1, 2'd1, 0, 32'h0);
        step("jr_to_top", RDY | JR, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 1, 2'd1, 1, 32'h0);
        step("wrap_to_zero", RDY, 0, 0, 0, 32'h0, 1, 2'd1, 0, 32'h0);
        while (exp_q.size() > 0) begin
            obs_t e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if ({o.pc, o.p4, o.vld, o.st, o.mis, o.epc} !== {e.pc, e.p4, e.vld, e.st, e.mis, e.epc}) begin
                miscompares++;
                $display("FAIL %s: got pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h, want pc=%h p4=%h vld=%b st=%0d mis=%b epc=%h",
                         e.tag, o.pc, o.p4, o.vld, o.st, o.mis, o.epc, e.pc, e.p4, e.vld, e.st, e.mis, e.epc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_jr();
        test_exception();
        test_halt();
        test_reset_recovery();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "time limit");
    end

endmodule
